// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry
//   Scans a 4x4 active-low matrix keypad, debounces whole scan frames and
//   decodes the accepted key. Digit keys shift into a two-digit BCD register
//   that drives the 7-segment display driver directly.
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous reset, active-high
//   COL        out  4  column strobes, active-low, exactly one bit low
//   ROW        in   4  row sense lines, active-low, pulled high externally
//   BCD1       out  4  tens digit (0-9)
//   BCD0       out  4  units digit (0-9)
//   key_valid  out  1  one-cycle pulse when a key press is accepted
//   key_code   out  4  code of last accepted key, held until next accept
//
// FSM (evaluated only on the frame-end cycle)
//   state    | meaning
//   S_IDLE   | no key, waiting for a single-key frame
//   S_DEB    | candidate key seen, counting identical frames
//   S_HELD   | key accepted, waiting for an empty frame
//   S_REL    | empty frames seen, counting toward release
module keypad_bcd_entry #(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] COL,
   input  logic [3:0] ROW,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DEB  = 2'd1;
   localparam logic [1:0] S_HELD = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;

   logic [DW-1:0] div_q, div_d;
   logic [1:0]    slot_q, slot_d;
   logic [1:0]    nkey_q, nkey_d;     // keys seen so far this frame, saturates at 2
   logic [3:0]    fcode_q, fcode_d;
   logic [1:0]    state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bcd1_q, bcd1_d;
   logic [3:0]    bcd0_q, bcd0_d;
   logic          kv_q, kv_d;
   logic [3:0]    kc_q, kc_d;

   logic          slot_end, frame_end;
   logic [3:0]    row_low;
   logic [2:0]    row_n, tot_n;
   logic [1:0]    row_idx;
   logic [3:0]    slot_code, code_m;
   logic          f_none, f_key, accept;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   // ROW is sampled directly on the slot's last cycle; the board is expected
   // to present clean, settled levels by then given the long slot time.
   assign row_low   = ~ROW;
   assign slot_end  = (div_q == DIV_LAST);
   assign frame_end = slot_end && (slot_q == 2'd3);
   assign COL       = ~(4'b0001 << slot_q);

   always_comb begin
      row_n = {2'b00, row_low[0]} + {2'b00, row_low[1]}
            + {2'b00, row_low[2]} + {2'b00, row_low[3]};
      if (row_low[0])      row_idx = 2'd0;
      else if (row_low[1]) row_idx = 2'd1;
      else if (row_low[2]) row_idx = 2'd2;
      else                 row_idx = 2'd3;
      slot_code = key_map(row_idx, slot_q);
      // Frame totals including the slot being sampled right now
      tot_n  = {1'b0, nkey_q} + row_n;
      code_m = (row_n != 3'd0) ? slot_code : fcode_q;
      f_none = (tot_n == 3'd0);
      f_key  = (tot_n == 3'd1);
   end

   always_comb begin
      div_d   = slot_end ? '0 : div_q + DW'(1);
      slot_d  = slot_end ? slot_q + 2'd1 : slot_q;
      nkey_d  = nkey_q;
      fcode_d = fcode_q;
      if (slot_end) begin
         if (frame_end) begin
            nkey_d  = 2'd0;
            fcode_d = 4'd0;
         end else begin
            nkey_d  = (tot_n >= 3'd2) ? 2'd2 : tot_n[1:0];
            fcode_d = code_m;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      if (frame_end) begin
         case (state_q)
            S_IDLE: begin
               if (f_key) begin
                  cand_d = code_m;
                  cnt_d  = CNT_ONE;
                  if (CNT_LAST == CNT_ONE) begin
                     accept  = 1'b1;
                     state_d = S_HELD;
                  end else begin
                     state_d = S_DEB;
                  end
               end
            end
            S_DEB: begin
               if (f_key) begin
                  if (code_m == cand_q) begin
                     cnt_d = cnt_q + CNT_ONE;
                     if (cnt_q + CNT_ONE == CNT_LAST) begin
                        accept  = 1'b1;
                        state_d = S_HELD;
                     end
                  end else begin
                     cand_d = code_m;
                     cnt_d  = CNT_ONE;
                  end
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
            S_HELD: begin
               if (f_none) begin
                  if (CNT_LAST == CNT_ONE) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = S_REL;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            default: begin
               if (f_none) begin
                  if (cnt_q + CNT_ONE == CNT_LAST) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  state_d = S_HELD;
               end
            end
         endcase
      end
   end

   always_comb begin
      kv_d   = accept;
      kc_d   = kc_q;
      bcd1_d = bcd1_q;
      bcd0_d = bcd0_q;
      if (accept) begin
         kc_d = code_m;
         if (code_m <= 4'd9) begin
            bcd1_d = bcd0_q;
            bcd0_d = code_m;
         end else if (code_m == 4'hE) begin
            bcd1_d = 4'd0;
            bcd0_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         slot_q  <= 2'd0;
         nkey_q  <= 2'd0;
         fcode_q <= 4'd0;
         state_q <= S_IDLE;
         cand_q  <= 4'd0;
         cnt_q   <= '0;
         bcd1_q  <= 4'd0;
         bcd0_q  <= 4'd0;
         kv_q    <= 1'b0;
         kc_q    <= 4'd0;
      end else begin
         div_q   <= div_d;
         slot_q  <= slot_d;
         nkey_q  <= nkey_d;
         fcode_q <= fcode_d;
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         bcd1_q  <= bcd1_d;
         bcd0_q  <= bcd0_d;
         kv_q    <= kv_d;
         kc_q    <= kc_d;
      end
   end

   assign BCD1      = bcd1_q;
   assign BCD0      = bcd0_q;
   assign key_valid = kv_q;
   assign key_code  = kc_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb_keypad_bcd_entry
//   Drives a physical 4x4 keypad model (pressed-key matrix resolved against
//   the column strobes) and compares the DUT every cycle against a frame-level
//   reference model built from the key map and debounce rules.
module tb_keypad_bcd_entry;

   localparam int SD = 4;
   localparam int DB = 2;
   localparam int FR = 4 * SD;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] COL, ROW, BCD1, BCD0, key_code;
   logic       key_valid;
   logic [15:0] pressed;   // bit r*4+c : key at row r, column c held down

   always #5 clk = ~clk;

   keypad_bcd_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk(clk), .rst(rst), .COL(COL), .ROW(ROW),
      .BCD1(BCD1), .BCD0(BCD0), .key_valid(key_valid), .key_code(key_code)
   );

   always_comb begin
      ROW = 4'hF;
      for (int r = 0; r < 4; r++)
         if (|(pressed[r*4 +: 4] & ~COL)) ROW[r] = 1'b0;
   end

   logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};

   // reference model
   int          pos;         // position in frame of the cycle now in progress
   logic [15:0] fkeys;       // keys observed so far in this frame
   int          phase;       // 0 idle, 1 debouncing, 2 held, 3 releasing
   int          mcnt;
   logic [3:0]  mcand, mb1, mb0, mkc;
   logic        mkv;

   int vecs = 0;
   int errs = 0;
   int kv_seen = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_accept(input logic [3:0] code);
      mkv = 1'b1;
      mkc = code;
      if (code <= 4'd9) begin
         mb1 = mb0;
         mb0 = code;
      end else if (code == 4'hE) begin
         mb1 = 4'd0;
         mb0 = 4'd0;
      end
   endtask

   task automatic frame_rules(input int n, input logic [3:0] code);
      case (phase)
         0: if (n == 1) begin
               mcand = code; mcnt = 1;
               if (mcnt == DB) begin do_accept(code); phase = 2; end
               else phase = 1;
            end
         1: if (n == 1) begin
               if (code == mcand) mcnt++;
               else begin mcand = code; mcnt = 1; end
               if (mcnt == DB) begin do_accept(code); phase = 2; end
            end else begin
               phase = 0; mcnt = 0;
            end
         2: if (n == 0) begin
               mcnt = 1;
               phase = (mcnt == DB) ? 0 : 3;
            end
         default: if (n == 0) begin
               mcnt++;
               if (mcnt == DB) begin phase = 0; mcnt = 0; end
            end else phase = 2;
      endcase
   endtask

   task automatic model_edge();
      int s, n;
      logic [3:0] code;
      if (rst) begin
         pos = 0; fkeys = '0; phase = 0; mcnt = 0;
         mcand = 0; mb1 = 0; mb0 = 0; mkv = 0; mkc = 0;
      end else begin
         mkv = 1'b0;
         s = pos / SD;
         if (pos % SD == SD - 1)
            for (int r = 0; r < 4; r++)
               if (pressed[r*4 + s]) fkeys[r*4 + s] = 1'b1;
         if (pos == FR - 1) begin
            n = $countones(fkeys);
            code = 4'd0;
            for (int i = 0; i < 16; i++) if (fkeys[i]) code = KMAP[i];
            frame_rules(n, code);
            fkeys = '0;
         end
         pos = (pos + 1) % FR;
      end
   endtask

   task automatic tick();
      logic [3:0] ecol;
      @(posedge clk);
      #1;
      model_edge();
      ecol = 4'b0001 << (pos / SD);
      ecol = ~ecol;
      chk("col", {4'h0, COL}, {4'h0, ecol});
      chk("key_valid", {7'h0, key_valid}, {7'h0, mkv});
      chk("key_code", {4'h0, key_code}, {4'h0, mkc});
      chk("bcd", {BCD1, BCD0}, {mb1, mb0});
      if (key_valid === 1'b1) kv_seen++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic align();
      for (int i = 0; i < FR && pos != 0; i++) tick();
   endtask

   task automatic press_key(input int idx, input int frames);
      pressed = 16'h0001 << idx;
      run(frames * FR);
      pressed = '0;
      run(3 * FR);
   endtask

   int k0;

   initial begin
      rst = 1'b1;
      pressed = '0;
      run(3);
      chk("rst_col", {4'h0, COL}, 8'h0E);
      chk("rst_bcd", {BCD1, BCD0}, 8'h00);
      chk("rst_kv_kc", {3'b0, key_valid, key_code}, 8'h00);

      // idle scan
      rst = 1'b0;
      run(200);
      chk("idle_no_kv", kv_seen[7:0], 8'd0);

      // '5' held from a frame start: accept after the second frame end
      align();
      pressed = 16'h0001 << 5;
      run(31);
      chk("t2_early", kv_seen[7:0], 8'd0);
      tick();
      chk("t2_latency", {7'h0, key_valid}, 8'h01);
      chk("t2_code", {4'h0, key_code}, 8'h05);
      chk("t2_bcd", {BCD1, BCD0}, 8'h05);
      pressed = '0;
      run(3 * FR);

      // '7' shifts, '*' clears
      press_key(8, 3);
      chk("t3_bcd57", {BCD1, BCD0}, 8'h57);
      press_key(12, 3);
      chk("t3_star", {key_code, BCD1, BCD0}, 12'hE00);

      // long hold gives a single accept
      k0 = kv_seen;
      press_key(2, 20);
      chk("t4_one_kv", 8'(kv_seen - k0), 8'd1);
      chk("t4_bcd", {BCD1, BCD0}, 8'h03);

      // single-frame chatter is rejected
      align();
      k0 = kv_seen;
      press_key(2, 1);
      chk("t4_chatter", 8'(kv_seen - k0), 8'd0);

      // two keys together is MULTI, then 'A' leaves BCD alone
      k0 = kv_seen;
      pressed = 16'h0003;
      run(5 * FR);
      pressed = '0;
      run(3 * FR);
      chk("t5_multi", 8'(kv_seen - k0), 8'd0);
      press_key(3, 3);
      chk("t5_a", {key_code, BCD1, BCD0}, 12'hA03);

      // reset while '9' is held: re-debounced and accepted exactly once
      pressed = 16'h0001 << 10;
      run(3 * FR + $urandom_range(0, FR - 1));
      rst = 1'b1;
      run(2);
      chk("t6_rst", {BCD1, BCD0}, 8'h00);
      chk("t6_rst_kv_kc", {3'b0, key_valid, key_code}, 8'h00);
      rst = 1'b0;
      k0 = kv_seen;
      run(5 * FR);
      chk("t6_once", 8'(kv_seen - k0), 8'd1);
      chk("t6_bcd", {BCD1, BCD0}, 8'h09);
      pressed = '0;
      run(3 * FR);

      // random presses, chords and bounces against the model
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: pressed = '0;
            1: pressed = 16'h0001 << $urandom_range(0, 15);
            2: pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            default: pressed = 16'h0001 << $urandom_range(0, 15);
         endcase
         run($urandom_range(1, 5 * FR));
         if ($urandom_range(0, 1) == 1) begin
            pressed = '0;
            run($urandom_range(1, 3 * FR));
         end
      end
      pressed = '0;
      run(3 * FR);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
